// File: rtl/alu_adder_arb_pkg.sv
// Shared types and helpers for the adder arbiter: data width, state encoding
// and the round-robin pointer advance.
package alu_adder_arb_pkg;

   localparam int WIDTH_C     = 64;
   localparam int NUM_REQ_MAX = 8;

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } arb_state_e;

   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/adder_64bit.sv
// Two's-complement 64-bit adder with signed-overflow flag.
module adder_64bit (
   input  logic signed [63:0] A,
   input  logic signed [63:0] B,
   output logic signed [63:0] Sum,
   output logic               carry_overflow
);

   assign Sum            = A + B;
   assign carry_overflow = (A[63] == B[63]) && (Sum[63] != A[63]);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after the
// pointer wins; the index defaults to the pointer when nothing is granted.
module rr_arbiter
   import alu_adder_arb_pkg::*;
#(
   parameter int NUM_REQ = 3
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   input  logic                       en,
   output logic [NUM_REQ-1:0]         grant,
   output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

   localparam int ID_W = $clog2(NUM_REQ);

   logic [ID_W-1:0] idx;
   logic            found;

   always_comb begin
      grant     = '0;
      grant_idx = ptr;
      found     = 1'b0;
      idx       = ptr;
      for (int off = 0; off < NUM_REQ; off++) begin
         idx = ID_W'((int'(ptr) + off) % NUM_REQ);
         if (en && !found && req[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = idx;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_adder_arbiter.sv
// Shares one adder_64bit among NUM_REQ requesters with round-robin fairness;
// results are registered one cycle after acceptance and tagged with the owner id.
module alu_adder_arbiter
   import alu_adder_arb_pkg::*;
#(
   parameter int WIDTH   = WIDTH_C,
   parameter int NUM_REQ = 3
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*WIDTH-1:0]   req_a,
   input  logic [NUM_REQ*WIDTH-1:0]   req_b,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [$clog2(NUM_REQ)-1:0] rsp_id,
   output logic [WIDTH-1:0]           rsp_sum,
   output logic                       rsp_ovf
);

   localparam int ID_W = $clog2(NUM_REQ);

   arb_state_e               state_p1;
   logic [ID_W-1:0]          ptr_p1;
   logic                     can_accept_p0;
   logic [NUM_REQ-1:0]       grant_p0;
   logic [ID_W-1:0]          grant_idx_p0;
   logic                     vld_p0;
   logic signed [WIDTH-1:0]  add_a_p0;
   logic signed [WIDTH-1:0]  add_b_p0;
   logic signed [WIDTH-1:0]  sum_p0;
   logic                     ovf_p0;

   // Stage p0: arbitration and operand mux into the shared adder
   assign can_accept_p0 = rst_n && ((state_p1 == ST_EMPTY) || rsp_ready);

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
      .req       (req_valid),
      .ptr       (ptr_p1),
      .en        (can_accept_p0),
      .grant     (grant_p0),
      .grant_idx (grant_idx_p0)
   );

   assign req_ready = grant_p0;
   assign vld_p0    = |grant_p0;
   assign add_a_p0  = $signed(req_a[grant_idx_p0*WIDTH +: WIDTH]);
   assign add_b_p0  = $signed(req_b[grant_idx_p0*WIDTH +: WIDTH]);

   adder_64bit u_adder_64bit (
      .A              (add_a_p0),
      .B              (add_b_p0),
      .Sum            (sum_p0),
      .carry_overflow (ovf_p0)
   );

   // Stage p1: result register, occupancy state and round-robin pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_p1 <= ST_EMPTY;
         ptr_p1   <= '0;
         rsp_id   <= '0;
         rsp_sum  <= '0;
         rsp_ovf  <= 1'b0;
      end else if (vld_p0) begin
         state_p1 <= ST_FULL;
         ptr_p1   <= ID_W'(rr_next(int'(grant_idx_p0), NUM_REQ));
         rsp_id   <= grant_idx_p0;
         rsp_sum  <= sum_p0;
         rsp_ovf  <= ovf_p0;
      end else if (state_p1 == ST_FULL && rsp_ready) begin
         state_p1 <= ST_EMPTY;
      end
   end

   assign rsp_valid = (state_p1 == ST_FULL);

endmodule

// File: tb/tb_alu_adder_arbiter.sv
// Randomized and directed bench for alu_adder_arbiter against a cycle-level
// behavioural model of grant order, result occupancy and arithmetic.
module tb_alu_adder_arbiter;

   localparam int W = 64;
   localparam int N = 3;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*W-1:0]  req_a;
   logic [N*W-1:0]  req_b;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [1:0]      rsp_id;
   logic [W-1:0]    rsp_sum;
   logic            rsp_ovf;

   logic [W-1:0]    opa [N];
   logic [W-1:0]    opb [N];

   int n_checks = 0;
   int n_fail   = 0;

   // model state
   bit              m_full;
   int              m_ptr;
   int              m_id;
   logic [W-1:0]    m_sum;
   bit              m_ovf;

   always #5 clk = ~clk;

   alu_adder_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
      .rsp_ovf   (rsp_ovf)
   );

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_full = 1'b0;
      m_ptr  = 0;
      m_id   = 0;
      m_sum  = '0;
      m_ovf  = 1'b0;
   endtask

   // One cycle: called just after a falling edge, returns just after the next one.
   task automatic step(input logic [N-1:0] v, input logic rr);
      int g;
      logic [N-1:0]      exp_rdy;
      logic signed [W:0] wide;
      req_valid = v;
      rsp_ready = rr;
      for (int i = 0; i < N; i++) begin
         req_a[i*W +: W] = opa[i];
         req_b[i*W +: W] = opb[i];
      end
      #1;
      g = -1;
      if (!m_full || rr) begin
         for (int k = 0; k < N; k++) begin
            if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
         end
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", W'(req_ready), W'(exp_rdy));
      @(posedge clk);
      if (g >= 0) begin
         wide   = $signed({opa[g][W-1], opa[g]}) + $signed({opb[g][W-1], opb[g]});
         m_full = 1'b1;
         m_id   = g;
         m_sum  = opa[g] + opb[g];
         m_ovf  = (wide > $signed(65'sh0_7FFF_FFFF_FFFF_FFFF)) ||
                  (wide < $signed(65'sh1_8000_0000_0000_0000));
         m_ptr  = (g + 1) % N;
      end else if (m_full && rr) begin
         m_full = 1'b0;
      end
      #1;
      chk("rsp_valid", W'(rsp_valid), W'(m_full));
      chk("rsp_id",    W'(rsp_id),    W'(m_id));
      chk("rsp_sum",   rsp_sum,       m_sum);
      chk("rsp_ovf",   W'(rsp_ovf),   W'(m_ovf));
      @(negedge clk);
   endtask

   task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      opa[i] = a;
      opb[i] = b;
   endtask

   initial begin
      logic [W-1:0] held;
      int           fair_exp;
      for (int i = 0; i < N; i++) set_ops(i, '0, '0);
      rst_n     = 1'b0;
      req_valid = '1;
      rsp_ready = 1'b1;
      req_a     = '0;
      req_b     = '0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset_ready", W'(req_ready), '0);
      chk("reset_valid", W'(rsp_valid), '0);
      chk("reset_sum",   rsp_sum,       '0);
      rst_n = 1'b1;

      // single transfer from requester 0
      set_ops(0, 64'd2, -64'sd47);
      step(3'b001, 1'b1);
      chk("single_sum", rsp_sum, 64'hFFFF_FFFF_FFFF_FFD3);
      chk("single_id",  W'(rsp_id), '0);
      step(3'b000, 1'b1);

      // overflow corners on requester 1 then 2
      set_ops(1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
      step(3'b010, 1'b1);
      chk("ovf_pos_sum", rsp_sum, 64'h8000_0000_0000_0000);
      chk("ovf_pos_flag", W'(rsp_ovf), 64'd1);
      set_ops(2, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
      step(3'b100, 1'b1);
      chk("ovf_neg_sum", rsp_sum, '0);
      chk("ovf_neg_flag", W'(rsp_ovf), 64'd1);

      // fairness: pointer is now 0 again after the grant to 2
      for (int i = 0; i < N; i++) set_ops(i, 64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F);
      for (int c = 0; c < 6; c++) begin
         step(3'b111, 1'b1);
         fair_exp = c % 3;
         chk("fair_id",  W'(rsp_id), W'(fair_exp));
         chk("fair_sum", rsp_sum, '1);
      end

      // back-pressure with all requesters still asking
      set_ops(0, 64'd100, 64'd23);
      step(3'b111, 1'b1);
      held = rsp_sum;
      chk("bp_first", held, 64'd123);
      for (int c = 0; c < 4; c++) begin
         step(3'b111, 1'b0);
         chk("bp_hold", rsp_sum, 64'd123);
      end
      step(3'b111, 1'b1);
      chk("bp_drain_id", W'(rsp_id), 64'd1);

      // asynchronous reset while a result is pending
      req_valid = 3'b111;
      rsp_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("midrst_valid", W'(rsp_valid), '0);
      chk("midrst_ready", W'(req_ready), '0);
      chk("midrst_sum",   rsp_sum, '0);
      @(negedge clk);
      rst_n = 1'b1;
      step(3'b110, 1'b1);
      chk("midrst_first_id", W'(rsp_id), 64'd1);

      // randomized traffic
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 5))
               0:       set_ops(i, 64'h7FFF_FFFF_FFFF_FFFF, {$urandom, $urandom});
               1:       set_ops(i, 64'h8000_0000_0000_0000, {$urandom, $urandom});
               default: set_ops(i, {$urandom, $urandom}, {$urandom, $urandom});
            endcase
         end
         step(N'($urandom), ($urandom_range(0, 3) != 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
